fetch_unit: RTL and testbench

//  Instruction-fetch stage upstream of the MIPS decode/control logic. Owns the PC register.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit_next_pc_calc.sv | 30 +++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_pkg: types and constants shared by fetch, decode and control logic.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mips_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pcsel_e;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        WAIT  = 2'b01,
        EXEC  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_JR  = 6'h08;
    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;

    // Word-aligned, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit_if: instruction-memory request/response channel.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_next_pc_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | next_pc_calc: combinational next-PC resolution from pcsel.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] jr_target,
    input  pcsel_e      pcsel,
    output logic [31:0] next_pc
);
    // Opcode bits and the jr byte offset never influence the target.
    logic w_unused_bits;
    assign w_unused_bits = ^{instr[31:26], jr_target[1:0]};

    always_comb begin
        next_pc = pc_plus4;
        case (pcsel)
            PC_SEQ:  next_pc = pc_plus4;
            PC_BR:   next_pc = pc_plus4 + branch_offset(instr[15:0]);
            PC_J:    next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            PC_JR:   next_pc = {jr_target[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit: PC register, imem fetch FSM and instruction latch.             |
// | Optional FETCH_PERF_CNT_EN adds retire / taken counters.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      pcsel,
    input  logic [XLEN-1:0] jr_target,
    input  logic            hold,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_instret,
    output logic [31:0]     perf_taken
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] w_next_pc;
    logic            w_retire;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign pc       = pc_q;
    assign instr    = instr_q;

    assign instr_valid         = (state_q == EXEC);
    assign w_retire            = (state_q == EXEC) && !hold;
    // The request is masked while reset is high so nothing issues mid-reset.
    assign imem.imem_req_valid = (state_q == FETCH) && !reset;
    assign imem.imem_addr      = pc_q;

    next_pc_calc u_next_pc_calc (
        .pc_plus4  (pc_plus4),
        .instr     (instr_q),
        .jr_target (jr_target),
        .pcsel     (pcsel_e'(pcsel)),
        .next_pc   (w_next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            FETCH: begin
                if (imem.imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    instr_d = imem.imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (w_retire) begin
                    pc_d    = w_next_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instret_q, instret_d;
    logic [31:0] taken_q, taken_d;

    always_comb begin
        instret_d = instret_q;
        taken_d   = taken_q;
        if (w_retire) begin
            instret_d = instret_q + 32'd1;
            if (pcsel != PC_SEQ) begin
                taken_d = taken_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= 32'd0;
            taken_q   <= 32'd0;
        end else begin
            instret_q <= instret_d;
            taken_q   <= taken_d;
        end
    end

    assign perf_instret = instret_q;
    assign perf_taken   = taken_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit: directed + randomized self-checking bench for fetch_unit.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pcsel;
    logic [31:0] jr_target;
    logic        hold;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_instret;
    logic [31:0] perf_taken;
`endif

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.RESET_PC(C_RESET_PC), .XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .pcsel       (pcsel),
        .jr_target   (jr_target),
        .hold        (hold),
        .imem        (bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_instret(perf_instret),
        .perf_taken  (perf_taken)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic [31:0] cur_word;
    int          exec_cyc;
    int          prev_exec_cyc;
    int          m_instret;
    int          m_taken;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rules expressed as plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                               input logic [1:0] sel, input logic [31:0] jr);
        logic [31:0] seq;
        int          disp;
        seq = cur_pc + 32'd4;
        case (sel)
            2'd0: return seq;
            2'd1: begin
                disp = int'($signed(word[15:0])) * 4;
                return seq + 32'(disp);
            end
            2'd2: return (seq & 32'hF000_0000) + ({6'd0, word[25:0]} * 32'd4);
            default: return (jr / 32'd4) * 32'd4;
        endcase
    endfunction

    // Drive one fetch from FETCH through to EXEC, checking the handshake on the way.
    task automatic fetch_phase(input logic [31:0] word, input int rdy_dly, input int rsp_dly);
        int t = 0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        while (bus.imem_req_valid !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("fetch_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("fetch_addr", bus.imem_addr, exp_pc);
        chk("fetch_instr_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rdata     = $urandom;
            pcsel              = 2'($urandom);
            @(posedge clk); #1;
            chk("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
            chk("stall_addr", bus.imem_addr, exp_pc);
            chk("stall_instr_valid", {31'd0, instr_valid}, 32'd0);
        end
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
        chk("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            @(posedge clk); #1;
            chk("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
            chk("wait_instr_valid", {31'd0, instr_valid}, 32'd0);
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata     = word;
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata     = $urandom;
        cur_word      = word;
        prev_exec_cyc = exec_cyc;
        exec_cyc      = cyc;
        chk("exec_instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_instr", instr, word);
        chk("exec_pc", pc, exp_pc);
        chk("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
    endtask

    task automatic exec_phase(input logic [1:0] sel, input logic [31:0] jr, input int hold_n);
        for (int i = 0; i < hold_n; i++) begin
            hold      = 1'b1;
            pcsel     = 2'($urandom);
            jr_target = $urandom;
            @(posedge clk); #1;
            chk("hold_instr_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_pc", pc, exp_pc);
            chk("hold_instr", instr, cur_word);
            chk("hold_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        end
        hold      = 1'b0;
        pcsel     = sel;
        jr_target = jr;
        @(posedge clk); #1;
        exp_pc = model_next(exp_pc, cur_word, sel, jr);
        m_instret++;
        if (sel != 2'd0) m_taken++;
        chk("retire_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("retire_pc", pc, exp_pc);
        chk("retire_addr", bus.imem_addr, exp_pc);
        pcsel     = 2'($urandom);
        jr_target = $urandom;
    endtask

    task automatic run_instr(input logic [31:0] word, input logic [1:0] sel, input logic [31:0] jr,
                             input int hold_n, input int rdy_dly, input int rsp_dly);
        fetch_phase(word, rdy_dly, rsp_dly);
        exec_phase(sel, jr, hold_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        hold               = 1'b0;
        pcsel              = 2'd0;
        jr_target          = 32'd0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata     = 32'd0;
        exec_cyc           = 0;
        prev_exec_cyc      = 0;
        m_instret          = 0;
        m_taken            = 0;
        exp_pc             = C_RESET_PC;
        cur_word           = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, C_RESET_PC);
        reset = 1'b0;

        // Sequential flow, back-to-back: EXEC every third cycle
        run_instr(32'h2008_0001, 2'd0, 32'd0, 0, 0, 0);
        run_instr(32'h2009_0002, 2'd0, 32'd0, 0, 0, 0);
        chk("cadence_1", 32'(exec_cyc - prev_exec_cyc), 32'd3);
        run_instr(32'h200A_0003, 2'd0, 32'd0, 0, 0, 0);
        chk("cadence_2", 32'(exec_cyc - prev_exec_cyc), 32'd3);
        run_instr(32'h0000_0000, 2'd0, 32'd0, 0, 0, 0);
        chk("seq_pc_0x10", exp_pc, 32'h0040_0010);

        // BEQ with imm=-1 branches back to itself
        run_instr(32'h1022_FFFF, 2'd1, 32'd0, 0, 0, 0);
        chk("beq_self_addr", bus.imem_addr, 32'h0040_0010);

        // J and JR targets from pc=0x00400020
        run_instr(32'h0000_0000, 2'd3, 32'h0040_0020, 0, 0, 0);
        run_instr(32'h0800_0040, 2'd2, 32'd0, 0, 0, 0);
        chk("j_target_addr", bus.imem_addr, 32'h0000_0100);
        run_instr(32'h0000_0000, 2'd3, 32'h0040_0020, 0, 0, 0);
        run_instr(32'h0800_0040, 2'd3, 32'h0040_0103, 0, 0, 0);
        chk("jr_target_addr", bus.imem_addr, 32'h0040_0100);

        // Hold in EXEC for 4 cycles, ready withheld for 3 cycles
        run_instr(32'h2010_0005, 2'd0, 32'd0, 4, 3, 1);

        // Reset during WAIT abandons the fetch
        fetch_phase(32'h0, 0, 0);
        exec_phase(2'd0, 32'd0, 0);
        bus.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
        chk("rstwait_in_wait", {31'd0, bus.imem_req_valid}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstwait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rstwait_pc", pc, C_RESET_PC);
        reset  = 1'b0;
        exp_pc = C_RESET_PC;
        chk("rstwait_first_addr", bus.imem_addr, C_RESET_PC);

        // PC wrap from 0xFFFFFFFC
        run_instr(32'h0000_0000, 2'd3, 32'hFFFF_FFFE, 0, 0, 0);
        run_instr(32'h0000_0000, 2'd0, 32'd0, 0, 0, 0);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Reset together with hold while in EXEC: reset wins
        fetch_phase(32'h1234_5678, 0, 0);
        hold  = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstexec_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstexec_pc", pc, C_RESET_PC);
        chk("rstexec_instr", instr, 32'd0);
        hold      = 1'b0;
        reset     = 1'b0;
        exp_pc    = C_RESET_PC;
        m_instret = 0;
        m_taken   = 0;

`ifdef FETCH_PERF_CNT_EN
        chk("perf_clr_instret", perf_instret, 32'd0);
        chk("perf_clr_taken", perf_taken, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5 || i == 8)
                run_instr(32'h1000_0003, 2'd1, 32'd0, 0, 0, 0);
            else
                run_instr(32'h2000_0000, 2'd0, 32'd0, 0, 0, 0);
        end
        chk("perf_instret_10", perf_instret, 32'd10);
        chk("perf_taken_3", perf_taken, 32'd3);
`endif

        // Randomized instruction stream
        for (int i = 0; i < 24; i++) begin
            run_instr($urandom, 2'($urandom_range(0, 3)), $urandom,
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

`ifdef FETCH_PERF_CNT_EN
        chk("perf_instret_rand", perf_instret, 32'(m_instret));
        chk("perf_taken_rand", perf_taken, 32'(m_taken));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
